// File: rtl/mure_pkg.sv
// Shared types and default widths for the trace-encoder block FSM.
// - itype_e      : E-trace instruction type encoding
// - state_e      : accumulator state (no open block / open block)
// - fifo_entry_s : commit-FIFO entry at the default widths; the block
//                  parameters override these widths through te_block_if.
package mure_pkg;

  localparam int XLEN_D        = 64;
  localparam int IRETIRE_LEN_D = 32;
  localparam int ITYPE_LEN_D   = 3;
  localparam int CAUSE_LEN_D   = 5;
  localparam int PRIV_LEN_D    = 2;

  typedef enum logic [2:0] {
    IT_STD  = 3'd0,
    IT_EXC  = 3'd1,
    IT_INT  = 3'd2,
    IT_ERET = 3'd3,
    IT_NTB  = 3'd4,
    IT_TB   = 3'd5,
    IT_UJ   = 3'd6,
    IT_RSV  = 3'd7
  } itype_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } state_e;

  typedef struct packed {
    logic [XLEN_D-1:0]      pc;
    logic                   compressed;
    logic [ITYPE_LEN_D-1:0] itype;
    logic [CAUSE_LEN_D-1:0] cause;
    logic [XLEN_D-1:0]      tval;
    logic [PRIV_LEN_D-1:0]  priv;
  } fifo_entry_s;

endpackage

// File: rtl/te_block_fsm_if.sv
// Commit-entry and block-record channels of te_block_fsm.
// - entry channel : entry_valid_i / entry_ready_o / entry_i, plus flush_i
// - record channel: valid_o / ready_i and the record fields
// Modports: slave = the block FSM, master = the commit-FIFO / encoder side.
interface te_block_if #(
  parameter int XLEN        = 64,
  parameter int IRETIRE_LEN = 32,
  parameter int ITYPE_LEN   = 3,
  parameter int CAUSE_LEN   = 5,
  parameter int PRIV_LEN    = 2
) ();

  // Same layout as mure_pkg::fifo_entry_s, at the overridden widths.
  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic                 compressed;
    logic [ITYPE_LEN-1:0] itype;
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [PRIV_LEN-1:0]  priv;
  } entry_t;

  logic                   entry_valid_i;
  logic                   entry_ready_o;
  entry_t                 entry_i;
  logic                   flush_i;
  logic                   valid_o;
  logic                   ready_i;
  logic [IRETIRE_LEN-1:0] iretire_o;
  logic                   ilastsize_o;
  logic [ITYPE_LEN-1:0]   itype_o;
  logic [CAUSE_LEN-1:0]   cause_o;
  logic [XLEN-1:0]        tval_o;
  logic [PRIV_LEN-1:0]    priv_o;
  logic [XLEN-1:0]        iaddr_o;

  modport slave (
    input  entry_valid_i, entry_i, flush_i, ready_i,
    output entry_ready_o, valid_o, iretire_o, ilastsize_o, itype_o,
           cause_o, tval_o, priv_o, iaddr_o
  );

  modport master (
    output entry_valid_i, entry_i, flush_i, ready_i,
    input  entry_ready_o, valid_o, iretire_o, ilastsize_o, itype_o,
           cause_o, tval_o, priv_o, iaddr_o
  );

endinterface

// File: rtl/te_block_fsm_rec.sv
// te_record_reg: one-entry valid/ready holding register for a block record.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   load_i        capture data_i (a new record) at this edge
//   ready_i       downstream accepts the held record
//   data_i/data_o packed record fields
//   valid_o       a record is held
//   free_o        register may be loaded this cycle (!valid_o || ready_i)
module te_record_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         ready_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         free_o
);

  assign free_o = !valid_o || ready_i;

  // A load on the same edge as a hand-off reloads and keeps valid high;
  // data only changes on load, so fields are stable while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/te_block_fsm.sv
// te_block_fsm: merges consecutive sequential committed instructions into
// E-trace instruction blocks and emits one record per block.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset (drops the open block)
//   bus    te_block_if.slave: commit entries in (valid/ready + flush),
//          block records out (valid/ready + iretire/ilastsize/itype/
//          cause/tval/priv/iaddr)
module te_block_fsm
  import mure_pkg::*;
#(
  parameter int XLEN        = XLEN_D,
  parameter int IRETIRE_LEN = IRETIRE_LEN_D,
  parameter int ITYPE_LEN   = ITYPE_LEN_D,
  parameter int CAUSE_LEN   = CAUSE_LEN_D,
  parameter int PRIV_LEN    = PRIV_LEN_D
) (
  input  logic     clk_i,
  input  logic     rst_i,
  te_block_if.slave bus
);

  localparam int REC_W = IRETIRE_LEN + 1 + ITYPE_LEN + CAUSE_LEN + XLEN + PRIV_LEN + XLEN;
  localparam logic [IRETIRE_LEN:0]  CNT_MAX = {1'b0, {IRETIRE_LEN{1'b1}}};
  localparam logic [ITYPE_LEN-1:0]  T_EXC   = ITYPE_LEN'(IT_EXC);
  localparam logic [ITYPE_LEN-1:0]  T_INT   = ITYPE_LEN'(IT_INT);
  localparam logic [ITYPE_LEN-1:0]  T_ERET  = ITYPE_LEN'(IT_ERET);
  localparam logic [ITYPE_LEN-1:0]  T_UJ    = ITYPE_LEN'(IT_UJ);
  localparam logic [ITYPE_LEN-1:0]  T_RSV   = ITYPE_LEN'(IT_RSV);

  state_e                 state_q, state_d;
  logic [XLEN-1:0]        iaddr_q, iaddr_d;
  logic [IRETIRE_LEN-1:0] cnt_q, cnt_d;
  logic                   last_q, last_d;
  logic [PRIV_LEN-1:0]    priv_q, priv_d;

  logic [XLEN-1:0]        e_pc, e_tval;
  logic                   e_c;
  logic [ITYPE_LEN-1:0]   e_it;
  logic [CAUSE_LEN-1:0]   e_cause;
  logic [PRIV_LEN-1:0]    e_priv;
  logic [IRETIRE_LEN-1:0] inc;
  logic [IRETIRE_LEN:0]   sum;
  logic                   is_open, is_trap, is_cf, sat;

  logic                   emit, ofree, rdy;
  logic [IRETIRE_LEN-1:0] r_iretire;
  logic                   r_last;
  logic [ITYPE_LEN-1:0]   r_itype;
  logic [CAUSE_LEN-1:0]   r_cause;
  logic [XLEN-1:0]        r_tval;
  logic [PRIV_LEN-1:0]    r_priv;
  logic [XLEN-1:0]        r_iaddr;
  logic [REC_W-1:0]       rec_d, rec_q;

  assign e_pc    = bus.entry_i.pc;
  assign e_c     = bus.entry_i.compressed;
  assign e_it    = bus.entry_i.itype;
  assign e_cause = bus.entry_i.cause;
  assign e_tval  = bus.entry_i.tval;
  assign e_priv  = bus.entry_i.priv;

  assign inc     = e_c ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
  assign sum     = {1'b0, cnt_q} + {1'b0, inc};
  assign sat     = sum > CNT_MAX;
  assign is_open = (state_q == ST_OPEN);
  assign is_trap = (e_it == T_EXC) || (e_it == T_INT);
  assign is_cf   = (e_it >= T_ERET);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      iaddr_q <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      priv_q  <= '0;
    end else begin
      state_q <= state_d;
      iaddr_q <= iaddr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      priv_q  <= priv_d;
    end
  end

  // Default record is "close the open block as itype 0"; the trap and
  // control-flow branches override fields. Any emission while the record
  // register is busy simply stalls (rdy stays 0, state held).
  always_comb begin
    state_d   = state_q;
    iaddr_d   = iaddr_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    priv_d    = priv_q;
    rdy       = 1'b0;
    emit      = 1'b0;
    r_iretire = cnt_q;
    r_last    = last_q;
    r_itype   = '0;
    r_cause   = '0;
    r_tval    = '0;
    r_priv    = priv_q;
    r_iaddr   = iaddr_q;
    if (rst_i) begin
      rdy = 1'b0;
    end else if (bus.flush_i && is_open) begin
      if (ofree) begin
        emit    = 1'b1;
        state_d = ST_IDLE;
      end
    end else if (bus.entry_valid_i) begin
      if (is_trap) begin
        if (is_open) begin
          // Close the block first; the trap gets its own record next edge.
          if (ofree) begin
            emit    = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (ofree) begin
          emit      = 1'b1;
          rdy       = 1'b1;
          r_iretire = '0;
          r_last    = 1'b0;
          r_itype   = e_it;
          r_cause   = e_cause;
          r_tval    = e_tval;
          r_priv    = e_priv;
          r_iaddr   = e_pc;
        end
      end else if (is_open && ((e_priv != priv_q) || sat)) begin
        if (ofree) begin
          emit    = 1'b1;
          state_d = ST_IDLE;
        end
      end else if (is_cf) begin
        if (ofree) begin
          emit      = 1'b1;
          rdy       = 1'b1;
          state_d   = ST_IDLE;
          r_iretire = is_open ? sum[IRETIRE_LEN-1:0] : inc;
          r_last    = !e_c;
          r_itype   = (e_it == T_RSV) ? T_UJ : e_it;
          r_priv    = e_priv;
          r_iaddr   = is_open ? iaddr_q : e_pc;
        end
      end else begin
        // Sequential instruction: accumulate, never needs the output.
        rdy    = 1'b1;
        last_d = !e_c;
        if (is_open) begin
          cnt_d = sum[IRETIRE_LEN-1:0];
        end else begin
          state_d = ST_OPEN;
          iaddr_d = e_pc;
          cnt_d   = inc;
          priv_d  = e_priv;
        end
      end
    end
  end

  assign bus.entry_ready_o = rdy;
  assign rec_d = {r_iretire, r_last, r_itype, r_cause, r_tval, r_priv, r_iaddr};

  te_record_reg #(.W(REC_W)) u_rec (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (emit),
    .ready_i (bus.ready_i),
    .data_i  (rec_d),
    .valid_o (bus.valid_o),
    .data_o  (rec_q),
    .free_o  (ofree)
  );

  assign {bus.iretire_o, bus.ilastsize_o, bus.itype_o, bus.cause_o,
          bus.tval_o, bus.priv_o, bus.iaddr_o} = rec_q;

endmodule
